mem_responder: RTL and testbench

Memory-side responder for the microcontroller's MAR/MDR memory handshake. It accepts a request (`mem_en`, `rw`, address from MAR, write data from MDR) and performs the read or write on an internal word array after a programmable number of wait states. It then raises `mfc` (memory function complete) and holds it until the requester drops `mem_en`, completing a four-phase handshake. A side-band preload port lets benches and boot logic fill the array while the block is idle.

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MAR/MDR four-phase handshake.
// A request is latched in IDLE, held for WAIT_CYCLES wait states, performed
// against an internal 16-bit word array, then acknowledged with mfc until the
// requester drops mem_en. A side-band preload port writes the array while idle.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              rw,
  input  logic [15:0]       addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              mfc,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          cnt;
  logic [3:0]          cnt_next;

  // Request copies; the live addr/rw/data_in are ignored after acceptance.
  logic [15:0]         req_addr;
  logic                req_rw;
  logic [15:0]         req_data;

  logic                accept;
  logic                do_access;
  logic                preload;
  logic                in_range;
  logic [ADDR_W-1:0]   idx;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [15:0]         mem_wdata;

  // Array contents are deliberately left out of reset.
  logic [15:0]         mem [DEPTH];

  // Any nonzero bit above the implemented address bits is out of range.
  assign in_range = ((req_addr >> ADDR_W) == 16'd0);
  assign idx      = req_addr[ADDR_W-1:0];

  assign mfc  = (state == S_ACK);
  assign busy = (state != S_IDLE);

  // Next-state and handshake decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    preload    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_en) begin
          // A request in the same cycle as ld_en wins; the preload is dropped.
          accept     = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = S_WAIT;
        end else if (ld_en) begin
          preload = 1'b1;
        end
      end
      S_WAIT: begin
        if (!mem_en) begin
          state_next = S_IDLE;
        end else if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          do_access  = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!mem_en) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Single array write port shared by preload and in-range request writes;
  // blocked while reset is asserted so a pending write is discarded.
  always_comb begin
    mem_we    = !rst && (preload || (do_access && in_range && !req_rw));
    mem_waddr = preload ? ld_addr : idx;
    mem_wdata = preload ? ld_data : req_data;
  end

  // Control state, request copies and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_addr <= 16'd0;
      req_rw   <= 1'b0;
      req_data <= 16'd0;
      data_out <= 16'd0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        req_addr <= addr;
        req_rw   <= rw;
        req_data <= data_in;
      end
      if (do_access) begin
        err <= !in_range;
        if (req_rw) data_out <= in_range ? mem[idx] : 16'd0;
      end
    end
  end

  // Word array write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance a uses default wait states,
// instance b uses zero wait states.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_mem_en = 1'b0, a_rw = 1'b0, a_ld_en = 1'b0;
  logic [15:0] a_addr = 16'd0, a_din = 16'd0, a_ld_data = 16'd0;
  logic [7:0]  a_ld_addr = 8'd0;
  logic [15:0] a_dout;
  logic        a_mfc, a_err, a_busy;

  logic        b_mem_en = 1'b0, b_rw = 1'b0, b_ld_en = 1'b0;
  logic [15:0] b_addr = 16'd0, b_din = 16'd0, b_ld_data = 16'd0;
  logic [7:0]  b_ld_addr = 8'd0;
  logic [15:0] b_dout;
  logic        b_mfc, b_err, b_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .mem_en(a_mem_en), .rw(a_rw), .addr(a_addr),
    .data_in(a_din), .data_out(a_dout), .mfc(a_mfc), .err(a_err),
    .busy(a_busy), .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mem_en(b_mem_en), .rw(b_rw), .addr(b_addr),
    .data_in(b_din), .data_out(b_dout), .mfc(b_mfc), .err(b_err),
    .busy(b_busy), .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit z, input bit en, input bit rw_v,
                       input logic [15:0] a, input logic [15:0] d);
    if (!z) begin
      a_mem_en = en; a_rw = rw_v; a_addr = a; a_din = d;
    end else begin
      b_mem_en = en; b_rw = rw_v; b_addr = a; b_din = d;
    end
  endtask

  task automatic set_en(input bit z, input bit v);
    if (!z) a_mem_en = v;
    else    b_mem_en = v;
  endtask

  task automatic preload(input bit z, input logic [7:0] la, input logic [15:0] ld);
    if (!z) begin
      a_ld_en = 1'b1; a_ld_addr = la; a_ld_data = ld;
    end else begin
      b_ld_en = 1'b1; b_ld_addr = la; b_ld_data = ld;
    end
    tick();
    a_ld_en = 1'b0;
    b_ld_en = 1'b0;
  endtask

  // Raise a request and advance to just after the access edge E(waits+1).
  task automatic req_start(input bit z, input bit rw_v, input logic [15:0] a,
                           input logic [15:0] d, input int waits);
    drive(z, 1'b1, rw_v, a, d);
    repeat (waits + 2) tick();
  endtask

  task automatic req_end(input bit z);
    set_en(z, 1'b0);
    tick();
  endtask

  initial begin
    // Power-on reset
    repeat (2) tick();
    chk("rst_mfc",  {15'd0, a_mfc},  16'd0);
    chk("rst_err",  {15'd0, a_err},  16'd0);
    chk("rst_busy", {15'd0, a_busy}, 16'd0);
    chk("rst_dout", a_dout,          16'h0000);
    rst = 1'b0;
    tick();
    chk("rst_rel_busy", {15'd0, a_busy}, 16'd0);

    preload(1'b0, 8'h05, 16'hBEEF);
    preload(1'b0, 8'h00, 16'h7777);
    preload(1'b0, 8'h10, 16'h0001);

    // Preload then read, with addr changed after acceptance
    drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000);
    tick();
    chk("rd_e0_busy", {15'd0, a_busy}, 16'd1);
    chk("rd_e0_mfc",  {15'd0, a_mfc},  16'd0);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    tick();
    chk("rd_e1_mfc", {15'd0, a_mfc}, 16'd0);
    tick();
    chk("rd_e2_mfc", {15'd0, a_mfc}, 16'd0);
    tick();
    chk("rd_e3_mfc",  {15'd0, a_mfc}, 16'd1);
    chk("rd_e3_dout", a_dout,         16'hBEEF);
    chk("rd_e3_err",  {15'd0, a_err}, 16'd0);
    req_end(1'b0);
    chk("rd_fall_mfc",  {15'd0, a_mfc},  16'd0);
    chk("rd_fall_busy", {15'd0, a_busy}, 16'd0);

    // Write then read back
    req_start(1'b0, 1'b0, 16'h00A0, 16'h1234, 2);
    chk("wr_mfc",  {15'd0, a_mfc}, 16'd1);
    chk("wr_err",  {15'd0, a_err}, 16'd0);
    chk("wr_dout_held", a_dout,    16'hBEEF);
    req_end(1'b0);
    req_start(1'b0, 1'b1, 16'h00A0, 16'h0000, 2);
    chk("rb_dout", a_dout, 16'h1234);
    req_end(1'b0);

    // Out-of-range write, then asynchronous reset during its ACK
    req_start(1'b0, 1'b0, 16'h0100, 16'h5555, 2);
    chk("oor_wr_mfc",  {15'd0, a_mfc}, 16'd1);
    chk("oor_wr_err",  {15'd0, a_err}, 16'd1);
    chk("oor_wr_dout", a_dout,         16'h1234);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_mfc",  {15'd0, a_mfc},  16'd0);
    chk("arst_err",  {15'd0, a_err},  16'd0);
    chk("arst_busy", {15'd0, a_busy}, 16'd0);
    chk("arst_dout", a_dout,          16'h0000);
    set_en(1'b0, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    chk("arst_rel_busy", {15'd0, a_busy}, 16'd0);

    req_start(1'b0, 1'b1, 16'h0000, 16'h0000, 2);
    chk("noalias_dout", a_dout,         16'h7777);
    chk("noalias_err",  {15'd0, a_err}, 16'd0);
    req_end(1'b0);
    req_start(1'b0, 1'b1, 16'h0100, 16'h0000, 2);
    chk("oor_rd_dout", a_dout,         16'h0000);
    chk("oor_rd_err",  {15'd0, a_err}, 16'd1);
    req_end(1'b0);

    // Abort in WAIT by dropping mem_en
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'hFFFF);
    tick();
    chk("abort_e0_busy", {15'd0, a_busy}, 16'd1);
    set_en(1'b0, 1'b0);
    tick();
    chk("abort_busy", {15'd0, a_busy}, 16'd0);
    chk("abort_mfc",  {15'd0, a_mfc},  16'd0);
    tick();
    chk("abort_mfc2", {15'd0, a_mfc},  16'd0);
    req_start(1'b0, 1'b1, 16'h0010, 16'h0000, 2);
    chk("abort_rb", a_dout, 16'h0001);
    req_end(1'b0);

    // Reset in WAIT discards the write
    drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'hFFFF);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("wrst_busy", {15'd0, a_busy}, 16'd0);
    tick();
    rst = 1'b0;
    set_en(1'b0, 1'b0);
    tick();
    req_start(1'b0, 1'b1, 16'h0010, 16'h0000, 2);
    chk("wrst_rb", a_dout, 16'h0001);
    req_end(1'b0);

    // Zero wait states, held request through ACK, request beats preload
    preload(1'b1, 8'h21, 16'h1111);
    preload(1'b1, 8'h20, 16'hCAFE);
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000);
    b_ld_en = 1'b1; b_ld_addr = 8'h21; b_ld_data = 16'hDEAD;
    tick();
    b_ld_en = 1'b0;
    chk("z_e0_busy", {15'd0, b_busy}, 16'd1);
    chk("z_e0_mfc",  {15'd0, b_mfc},  16'd0);
    tick();
    chk("z_e1_mfc",  {15'd0, b_mfc}, 16'd1);
    chk("z_e1_dout", b_dout,         16'hCAFE);
    drive(1'b1, 1'b1, 1'b1, 16'h0021, 16'h0000);
    tick();
    chk("z_hold_mfc",  {15'd0, b_mfc}, 16'd1);
    chk("z_hold_dout", b_dout,         16'hCAFE);
    set_en(1'b1, 1'b0);
    tick();
    chk("z_idle_mfc",  {15'd0, b_mfc},  16'd0);
    chk("z_idle_busy", {15'd0, b_busy}, 16'd0);
    set_en(1'b1, 1'b1);
    tick();
    chk("z2_e0_mfc", {15'd0, b_mfc}, 16'd0);
    tick();
    chk("z2_e1_mfc",   {15'd0, b_mfc}, 16'd1);
    chk("z2_ld_drop",  b_dout,         16'h1111);
    req_end(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
